// File: rtl/ofm_reader.sv
// Drains N OFM words from a BRAM with one-cycle read latency onto a valid/ready stream.
// Optional OFM_READER_CLEAR_EN adds a trailing clear-write per read so the OFM starts at zero for the next layer.
module ofm_reader #(
  parameter  int FM_SIZE     = 4,
  parameter  int KERNEL_SIZE = 3,
  parameter  int PADDING     = 0,
  parameter  int STRIDE      = 1,
  parameter  int DATA_WIDTH  = 48,
  localparam int OUT_SIZE    = ((FM_SIZE - KERNEL_SIZE + 2*PADDING) / STRIDE) + 1,
  localparam int AW          = $clog2(OUT_SIZE**2) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [AW-1:0]         i_count,
  output logic                  o_ofm_r_en,
  output logic [AW-1:0]         o_ofm_r_addr,
  input  logic [DATA_WIDTH-1:0] i_ofm_data,
  output logic                  o_tvalid,
  input  logic                  i_tready,
  output logic [DATA_WIDTH-1:0] o_tdata,
  output logic                  o_tlast,
  output logic                  o_busy,
  output logic                  o_done
`ifdef OFM_READER_CLEAR_EN
  ,
  output logic                  o_ofm_w_en,
  output logic [AW-1:0]         o_ofm_w_addr
`endif
);

  localparam logic [AW-1:0] TOTAL = AW'(OUT_SIZE * OUT_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   n_q, n_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   n_clamped;
  logic            inflight_q;
  logic            inflight_last_q;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic                  fifo_last_q [2];
  logic                  fifo_wp_q;
  logic                  fifo_rp_q;
  logic [1:0]            fifo_cnt_q;

  logic       push;
  logic       pop;
  logic [1:0] occ_eff;
  logic       rd_en;
  logic       rd_is_last;
  logic       head_last;

  assign n_clamped  = (i_count > TOTAL) ? TOTAL : i_count;
  assign push       = inflight_q;
  assign pop        = (fifo_cnt_q != 2'd0) && i_tready;
  assign head_last  = fifo_last_q[fifo_rp_q];

  // A beat leaving this cycle frees its slot, so a read may issue every cycle
  // while i_tready stays high without ever exceeding two words outstanding.
  assign occ_eff    = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign rd_en      = (state_q == DRAIN) && (rd_ptr_q != n_q) && (occ_eff < 2'd2);
  assign rd_is_last = (rd_ptr_q == n_q - AW'(1));

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    rd_ptr_d = rd_ptr_q;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          n_d      = n_clamped;
          rd_ptr_d = '0;
          state_d  = (n_clamped == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        o_busy = 1'b1;
        if (rd_en) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          if (rd_is_last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        o_busy = 1'b1;
        if (pop && head_last) state_d = DONE;
      end
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q[0]  <= '0;
      fifo_data_q[1]  <= '0;
      fifo_last_q[0]  <= 1'b0;
      fifo_last_q[1]  <= 1'b0;
      fifo_wp_q       <= 1'b0;
      fifo_rp_q       <= 1'b0;
      fifo_cnt_q      <= 2'd0;
    end else begin
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en && rd_is_last;
      if (push) begin
        fifo_data_q[fifo_wp_q] <= i_ofm_data;
        fifo_last_q[fifo_wp_q] <= inflight_last_q;
        fifo_wp_q              <= ~fifo_wp_q;
      end
      if (pop) fifo_rp_q <= ~fifo_rp_q;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign o_ofm_r_en   = rd_en;
  assign o_ofm_r_addr = rd_ptr_q;
  assign o_tvalid     = (fifo_cnt_q != 2'd0);
  assign o_tdata      = fifo_data_q[fifo_rp_q];
  assign o_tlast      = o_tvalid && head_last;

`ifdef OFM_READER_CLEAR_EN
  // Write data is tied to zero at the top level; this only supplies strobe and address.
  logic          w_en_q;
  logic [AW-1:0] w_addr_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
    end else begin
      w_en_q   <= rd_en;
      w_addr_q <= rd_ptr_q;
    end
  end

  assign o_ofm_w_en   = w_en_q;
  assign o_ofm_w_addr = w_addr_q;
`endif

endmodule

// File: tb/tb_ofm_reader.sv
// Scoreboard bench for ofm_reader: a BRAM model feeds the DUT, expected beats are queued at start.
// Build with OFM_READER_CLEAR_EN defined to exercise the clear-write path as well.
module tb_ofm_reader;
  localparam int DW = 48;
  localparam int AW = 3;
  localparam int NV = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_count = '0;
  logic          o_ofm_r_en;
  logic [AW-1:0] o_ofm_r_addr;
  logic [DW-1:0] i_ofm_data;
  logic          o_tvalid;
  logic          i_tready = 1'b1;
  logic [DW-1:0] o_tdata;
  logic          o_tlast;
  logic          o_busy;
  logic          o_done;
`ifdef OFM_READER_CLEAR_EN
  logic          o_ofm_w_en;
  logic [AW-1:0] o_ofm_w_addr;
`endif

  ofm_reader #(
    .FM_SIZE(4), .KERNEL_SIZE(3), .PADDING(0), .STRIDE(1), .DATA_WIDTH(DW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_count(i_count),
    .o_ofm_r_en(o_ofm_r_en), .o_ofm_r_addr(o_ofm_r_addr), .i_ofm_data(i_ofm_data),
    .o_tvalid(o_tvalid), .i_tready(i_tready), .o_tdata(o_tdata), .o_tlast(o_tlast),
    .o_busy(o_busy), .o_done(o_done)
`ifdef OFM_READER_CLEAR_EN
    , .o_ofm_w_en(o_ofm_w_en), .o_ofm_w_addr(o_ofm_w_addr)
`endif
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // BRAM model: registered read, optional zeroing write, bulk load on request.
  logic [DW-1:0] mem [8];
  logic [DW-1:0] load_vals [8];
  logic          load_req = 1'b0;
  always @(posedge i_clk) begin
    if (o_ofm_r_en) i_ofm_data <= mem[o_ofm_r_addr];
    if (load_req) for (int i = 0; i < 8; i++) mem[i] <= load_vals[i];
`ifdef OFM_READER_CLEAR_EN
    if (o_ofm_w_en) mem[o_ofm_w_addr] <= '0;
`endif
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;
  beat_t exp_q[$];

  // tready pattern 1,0,0,1 repeating when tog is set
  bit         tog = 1'b0;
  logic [3:0] pat = 4'b1001;
  int         tk = 0;
  initial forever begin
    @(posedge i_clk); #1;
    i_tready = tog ? pat[tk % 4] : 1'b1;
    tk++;
  end

  // Monitor / model state, owned by the monitor process only
  bit            model_busy = 1'b0;
  int            model_n = 0;
  int            start_s = 0;
  int            exp_addr = 0;
  int            issued = 0;
  int            popped = 0;
  int            reads_total = 0;
  int            beats = 0;
  int            run_beats = 0;
  int            last_beat_cyc = 0;
  int            prev_beat_cyc = 0;
  int            first_valid_cyc = -1;
  int            done_cnt = 0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] stall_d;
  logic          stall_l;
  int            w_exp_addr = 0;
  bit            prev_ren = 1'b0;

  initial forever begin
    @(negedge i_clk);
    if (!i_rst) begin
      exp_q.delete();
      model_busy = 1'b0;
      stall_prev = 1'b0;
      issued     = 0;
      popped     = 0;
      prev_ren   = 1'b0;
    end else begin
      if (i_start && !model_busy) begin
        model_busy      = 1'b1;
        model_n         = (int'(i_count) > NV) ? NV : int'(i_count);
        start_s         = cyc + 1;
        exp_addr        = 0;
        w_exp_addr      = 0;
        run_beats       = 0;
        first_valid_cyc = -1;
        for (int k = 0; k < model_n; k++) begin
          beat_t b;
          b.d = mem[k];
          b.l = (k == model_n - 1);
          exp_q.push_back(b);
        end
      end
      if (o_tvalid && !model_busy) check("spurious_valid", 1, 0);
      if (model_busy && model_n != 0 && cyc >= start_s && !o_done) check("busy", o_busy, 1);
      if (stall_prev) begin
        check("stall_valid", o_tvalid, 1);
        check("stall_data", o_tdata, stall_d);
        check("stall_last", o_tlast, stall_l);
      end
      stall_prev = o_tvalid && !i_tready;
      stall_d    = o_tdata;
      stall_l    = o_tlast;
      if (o_tvalid && first_valid_cyc < 0) begin
        first_valid_cyc = cyc;
        check("first_valid_lat", cyc, start_s + 2);
      end
      if (o_ofm_r_en) begin
        check("rd_addr", o_ofm_r_addr, exp_addr);
        check("rd_in_range", int'(o_ofm_r_addr) < model_n, 1);
        exp_addr++;
        issued++;
        reads_total++;
      end
      if (o_tvalid && i_tready) begin
        beats++;
        popped++;
        if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          beat_t b;
          b = exp_q.pop_front();
          check("tdata", o_tdata, b.d);
          check("tlast", o_tlast, b.l);
        end
        if (!tog && run_beats > 0) check("beat_consecutive", cyc, prev_beat_cyc + 1);
        prev_beat_cyc = cyc;
        last_beat_cyc = cyc;
        run_beats++;
      end
      if (o_ofm_r_en) check("outstanding_le2", (issued - popped) <= 2, 1);
`ifdef OFM_READER_CLEAR_EN
      if (o_ofm_w_en || prev_ren) check("clr_follows_read", o_ofm_w_en, prev_ren);
      if (o_ofm_w_en) begin
        check("clr_addr", o_ofm_w_addr, w_exp_addr);
        w_exp_addr++;
      end
`endif
      prev_ren = o_ofm_r_en;
      if (o_done) begin
        done_cnt++;
        check("done_expected", model_busy, 1);
        check("done_q_empty", exp_q.size(), 0);
        check("done_not_busy", o_busy, 0);
        if (model_n == 0) check("done_lat_n0", cyc, start_s);
        else check("done_after_last", cyc, last_beat_cyc + 1);
        model_busy = 1'b0;
      end
    end
  end

  task automatic load_default();
    load_vals[0] = DW'(5);
    load_vals[1] = DW'(-3);
    load_vals[2] = DW'(7);
    load_vals[3] = DW'(0);
    for (int i = 4; i < 8; i++) load_vals[i] = 48'hBAD0_0000_0BAD;
    @(posedge i_clk); #1; load_req = 1'b1;
    @(posedge i_clk); #1; load_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_r_en"}, o_ofm_r_en, 0);
    check({tag, "_r_addr"}, o_ofm_r_addr, 0);
    check({tag, "_tvalid"}, o_tvalid, 0);
    check({tag, "_tdata"}, o_tdata, 0);
    check({tag, "_tlast"}, o_tlast, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
`ifdef OFM_READER_CLEAR_EN
    check({tag, "_w_en"}, o_ofm_w_en, 0);
    check({tag, "_w_addr"}, o_ofm_w_addr, 0);
`endif
  endtask

  task automatic run(input string tag, input logic [AW-1:0] cnt, input int exp_beats,
                     input int exp_reads, input bit poke);
    int b0, d0, r0;
    bit got;
    b0 = beats; d0 = done_cnt; r0 = reads_total;
    @(posedge i_clk); #1; i_count = cnt; i_start = 1'b1;
    @(posedge i_clk); #1; i_start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(posedge i_clk); #1;
      i_start = poke && (i == 1);
      if (done_cnt != d0) got = 1'b1;
    end
    i_start = 1'b0;
    check({tag, "_done_seen"}, got, 1);
    repeat (3) @(posedge i_clk);
    #1;
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_beats"}, beats - b0, exp_beats);
    check({tag, "_reads"}, reads_total - r0, exp_reads);
    check({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, d0;
    bit reached;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_outputs("rst");
    i_rst = 1'b1;

    load_default();
    run("full", 3'd4, 4, 4, 1'b1);
`ifdef OFM_READER_CLEAR_EN
    for (int i = 0; i < NV; i++) check("clr_readback", mem[i], 0);
`endif

    load_default();
    tog = 1'b1;
    run("stall", 3'd4, 4, 4, 1'b0);
    tog = 1'b0;

    run("zero", 3'd0, 0, 0, 1'b0);

    // 9 does not fit the 3-bit count port; 7 and 5 both exceed the 4-entry map.
    load_default();
    run("clamp7", 3'd7, 4, 4, 1'b0);
    load_default();
    run("clamp5", 3'd5, 4, 4, 1'b0);

    load_default();
    b0 = beats; d0 = done_cnt;
    @(posedge i_clk); #1; i_count = 3'd4; i_start = 1'b1;
    @(posedge i_clk); #1; i_start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      @(posedge i_clk); #1;
      if (beats - b0 >= 2) reached = 1'b1;
    end
    check("abort_two_beats", reached, 1);
    i_rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (3) @(posedge i_clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    i_rst = 1'b1;
    load_default();
    run("restart", 3'd4, 4, 4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
